// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store controller: memory map, access-size and funct3 codes,
// fault causes, FSM states and the latched request record.
`ifndef MEM_DEPTH
`define MEM_DEPTH 1024
`endif

package lsu_ctrl_pkg;

    localparam logic [31:0] MEM_BASE_DEFAULT  = 32'h0100_0000;
    localparam int unsigned MEM_DEPTH_DEFAULT = `MEM_DEPTH;

    // dmemory access_size codes
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // RV32I load/store funct3 codes; stores only use the first three
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'b00,
        CAUSE_ILLEGAL    = 2'b01,
        CAUSE_MISALIGNED = 2'b10,
        CAUSE_RANGE      = 2'b11
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    typedef struct packed {
        logic        is_store;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        is_signed;
    } req_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_legal_funct3(input logic [2:0] funct3, input logic is_store);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !is_store;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_req_check.sv
// Combinational request checker: decodes funct3 into size/sign and flags illegal,
// misaligned or out-of-range requests. Also used by the pipeline hazard logic.
module lsu_req_check
    import lsu_ctrl_pkg::*;
#(
    parameter logic [31:0] MEM_BASE  = MEM_BASE_DEFAULT,
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic        is_store,
    output logic [1:0]  size,
    output logic        is_signed,
    output logic        fault,
    output cause_e      cause
);

    logic        legal;
    logic        misaligned;
    logic        out_of_range;
    logic [32:0] last_byte;
    logic [32:0] mem_end;

    assign size      = funct3[1:0];
    assign is_signed = !funct3[2];

    // 33-bit sums so an access starting near 32'hFFFF_FFFF cannot wrap back into range
    assign mem_end   = {1'b0, MEM_BASE} + 33'(MEM_DEPTH);
    assign last_byte = {1'b0, addr} + 33'(size_bytes(funct3[1:0])) - 33'd1;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        legal        = is_legal_funct3(funct3, is_store);
        misaligned   = 1'b0;
        out_of_range = (addr < MEM_BASE) || (last_byte >= mem_end);
        cause        = CAUSE_NONE;

        case (funct3[1:0])
            SIZE_H:  misaligned = addr[0];
            SIZE_W:  misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        if (!legal) begin
            cause = CAUSE_ILLEGAL;
        end else if (misaligned) begin
            cause = CAUSE_MISALIGNED;
        end else if (out_of_range) begin
            cause = CAUSE_RANGE;
        end
    end

    assign fault = (cause != CAUSE_NONE);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one request, checks it, performs at most one dmemory
// access, and returns load data or a fault on a valid/ready response channel.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter logic [31:0] MEM_BASE  = MEM_BASE_DEFAULT,
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [1:0]  resp_cause,

    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read_write,
    output logic [1:0]  mem_access_size,
    output logic        mem_is_signed,
    input  logic [31:0] mem_data_out
);

    state_e     state;
    req_t       req_q;
    logic       accept;
    logic       in_access;

    logic [1:0] chk_size;
    logic       chk_signed;
    logic       chk_fault;
    cause_e     chk_cause;

    // Checked on the raw request so a fault can be answered the cycle after accept
    lsu_req_check #(
        .MEM_BASE  (MEM_BASE),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_req_check (
        .funct3    (req_funct3),
        .addr      (req_addr),
        .is_store  (req_is_store),
        .size      (chk_size),
        .is_signed (chk_signed),
        .fault     (chk_fault),
        .cause     (chk_cause)
    );

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign in_access = (state == ST_ACCESS);

    // NOTE: the request latches carry no reset; they only reach dmemory in ACCESS,
    // which cannot be entered without first loading them.
    always_ff @(posedge clock) begin
        if (accept) begin
            req_q.is_store  <= req_is_store;
            req_q.addr      <= req_addr;
            req_q.wdata     <= req_wdata;
            req_q.size      <= chk_size;
            req_q.is_signed <= chk_signed;
        end
    end

    // NOTE: all state below is sequential, so only non-blocking assignments are used.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
            resp_cause <= CAUSE_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (chk_fault) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_fault <= 1'b1;
                            resp_cause <= chk_cause;
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end
                end

                ST_ACCESS: begin
                    // A store commits at this same edge; only loads return data
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= req_q.is_store ? 32'd0 : mem_data_out;
                    resp_fault <= 1'b0;
                    resp_cause <= CAUSE_NONE;
                end

                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_fault <= 1'b0;
                        resp_cause <= CAUSE_NONE;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

    // dmemory only ever sees a checked address; outside ACCESS it idles on a safe word read
    assign mem_address     = in_access ? req_q.addr : MEM_BASE;
    assign mem_data_in     = in_access ? req_q.wdata : 32'd0;
    assign mem_access_size = in_access ? req_q.size : SIZE_W;
    assign mem_is_signed   = in_access && req_q.is_signed;
    assign mem_read_write  = in_access && req_q.is_store && !reset;

endmodule
